// File: rtl/lag_pattern_gen_pkg.sv
// Shared types for the lag-test pattern generator.
// Video timing geometry, display modes and text geometry.
package lag_pattern_gen_pkg;

  typedef struct packed {
    logic [11:0] h_sync;
    logic [11:0] h_back_porch;
    logic [11:0] v_sync;
    logic [11:0] v_back_porch_1;
    logic [11:0] v_back_porch_2;
    logic [11:0] h_active;
    logic [11:0] h_field_width;
    logic [3:0]  h_lag_divider;
    logic [3:0]  v_lag_divider;
    logic [11:0] h_lag_start;
    logic [11:0] v_lag_start;
  } VideoMode;

  typedef enum logic [1:0] {
    WHITE  = 2'b00,
    COLOUR = 2'b01,
    STEADY = 2'b10,
    OFF    = 2'b11
  } lpg_mode_t;

  localparam int LPG_TEXT_ROW_H = 16;
  localparam int LPG_ROW_SHIFT  = $clog2(LPG_TEXT_ROW_H);

endpackage

// File: rtl/lag_pattern_gen_flash_sequencer.sv
// Frame tick detection, jittered flash period and bar on/off sequencing.
// Emits the onset trigger pulse and the current lit state.
module lpg_flash_sequencer
  import lag_pattern_gen_pkg::*;
#(
  parameter int CNT_W  = 6,
  parameter int META_W = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [11:0]      h_sync,
  input  logic [11:0]      h_back_porch,
  input  logic [11:0]      v_sync,
  input  logic [11:0]      v_back_porch_1,
  input  logic [11:0]      v_back_porch_2,
  input  logic [11:0]      counterX,
  input  logic [11:0]      counterY,
  input  logic             state,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] on_frames,
  input  lpg_mode_t        mode,
  output logic             starttrigger,
  output logic             lit,
  output lpg_mode_t        cur_mode
);

  localparam int FW = CNT_W + 1;

  logic [11:0]       tick_x;
  logic [11:0]       tick_y;
  logic              tick;
  logic              onset;
  logic              flashing;
  logic              full_on;
  logic              off_now;
  logic [FW-1:0]     frame_cnt;
  logic [FW-1:0]     eff_period;
  logic [FW-1:0]     limit;
  logic [META_W-1:0] meta_cnt;
  logic [CNT_W-1:0]  period_q;
  logic [CNT_W-1:0]  on_q;
  logic [CNT_W-1:0]  per_c;
  logic [CNT_W-1:0]  on_c;
  lpg_mode_t         mode_q;
  lpg_mode_t         mode_c;
  logic              lit_q;

  assign tick_x = h_sync + h_back_porch;
  assign tick_y = v_sync + (state ? v_back_porch_2 : v_back_porch_1);
  assign tick   = (counterX == tick_x) && (counterY == tick_y);
  assign onset  = tick && (frame_cnt == '0);

  // Config is live on the onset tick, then frozen for the cycle
  assign per_c  = onset ? period : period_q;
  assign on_c   = onset ? on_frames : on_q;
  assign mode_c = onset ? mode : mode_q;

  assign eff_period = (per_c == '0) ? FW'(1) : {1'b0, per_c};
  assign limit      = eff_period - FW'(1) + FW'(meta_cnt);
  assign full_on    = {1'b0, on_c} >= eff_period;
  assign off_now    = !full_on && (frame_cnt >= {1'b0, on_c});
  assign flashing   = (mode_c == WHITE) || (mode_c == COLOUR);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starttrigger <= 1'b0;
      frame_cnt    <= '0;
      meta_cnt     <= '0;
      lit_q        <= 1'b0;
      period_q     <= '0;
      on_q         <= '0;
      mode_q       <= WHITE;
    end else begin
      starttrigger <= onset && flashing;
      if (tick) begin
        meta_cnt  <= meta_cnt + 1'b1;
        frame_cnt <= (frame_cnt >= limit) ? '0 : frame_cnt + 1'b1;
        if (off_now) lit_q <= 1'b0;
        else if (onset) lit_q <= 1'b1;
      end
      if (onset) begin
        period_q <= period;
        on_q     <= on_frames;
        mode_q   <= mode;
      end
    end
  end

  always_comb begin
    lit = lit_q;
    unique case (mode_q)
      STEADY:  lit = 1'b1;
      OFF:     lit = 1'b0;
      default: lit = lit_q;
    endcase
  end

  assign cur_mode = mode_q;

endmodule

// File: rtl/lag_pattern_gen.sv
// Lag-test pattern generator: edge flash bars plus bitmap text rows,
// through a 2-stage registered pixel pipeline.
module lag_pattern_gen
  import lag_pattern_gen_pkg::*;
#(
  parameter int NUM_FIELDS     = 3,
  parameter int NUM_TEXT_LINES = 4,
  parameter int LINE_BITS      = 256,
  parameter int CNT_W          = 6,
  parameter int META_W         = 3
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  VideoMode                           videoMode,
  input  logic [11:0]                        counterX,
  input  logic [11:0]                        counterY,
  input  logic [11:0]                        vis_x,
  input  logic [11:0]                        vis_y,
  input  logic                               de,
  input  logic                               state,
  input  logic [NUM_FIELDS*12-1:0]           field_start,
  input  logic [NUM_FIELDS*12-1:0]           field_end,
  input  logic [CNT_W-1:0]                   period,
  input  logic [CNT_W-1:0]                   on_frames,
  input  logic [1:0]                         mode,
  input  logic [23:0]                        flash_rgb,
  input  logic [NUM_TEXT_LINES*LINE_BITS-1:0] text_bits,
  output logic                               starttrigger,
  output logic                               de_out,
  output logic [23:0]                        data
);

  localparam int ROW_W = (NUM_TEXT_LINES > 1) ? $clog2(NUM_TEXT_LINES) : 1;
  localparam int BIT_W = $clog2(LINE_BITS);
  localparam int IDX_W = $clog2(NUM_TEXT_LINES * LINE_BITS);

  logic        lit;
  lpg_mode_t   cur_mode;

  lpg_flash_sequencer #(
    .CNT_W  (CNT_W),
    .META_W (META_W)
  ) u_seq (
    .clock          (clock),
    .reset_n        (reset_n),
    .h_sync         (videoMode.h_sync),
    .h_back_porch   (videoMode.h_back_porch),
    .v_sync         (videoMode.v_sync),
    .v_back_porch_1 (videoMode.v_back_porch_1),
    .v_back_porch_2 (videoMode.v_back_porch_2),
    .counterX       (counterX),
    .counterY       (counterY),
    .state          (state),
    .period         (period),
    .on_frames      (on_frames),
    .mode           (lpg_mode_t'(mode)),
    .starttrigger   (starttrigger),
    .lit            (lit),
    .cur_mode       (cur_mode)
  );

  logic [12:0]      x_far;
  logic             edge_hit;
  logic             field_hit;
  logic             text_hit;
  logic [4:0]       row_sh;
  logic [11:0]      dy;
  logic [11:0]      row_full;
  logic [11:0]      xs;
  logic [11:0]      dx;

  logic             de_s1;
  logic             bar_s1;
  logic             text_s1;
  logic [ROW_W-1:0] row_s1;
  logic [BIT_W-1:0] bit_s1;
  logic [IDX_W-1:0] text_idx;
  logic [23:0]      pix;

  // Right edge test rearranged so a wide bar cannot underflow
  assign x_far    = {1'b0, vis_x} + {1'b0, videoMode.h_field_width};
  assign edge_hit = (vis_x < videoMode.h_field_width) ||
                    (x_far >= {1'b0, videoMode.h_active});

  always_comb begin
    field_hit = 1'b0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (vis_y >= field_start[i*12 +: 12] &&
          vis_y < field_end[i*12 +: 12])
        field_hit = 1'b1;
    end
  end

  assign row_sh   = 5'(LPG_ROW_SHIFT) + {1'b0, videoMode.v_lag_divider};
  assign dy       = vis_y - videoMode.v_lag_start;
  assign row_full = dy >> row_sh;
  assign xs       = vis_x >> videoMode.h_lag_divider;
  assign dx       = xs - videoMode.h_lag_start;
  assign text_hit = (vis_y >= videoMode.v_lag_start) &&
                    (row_full < 12'(NUM_TEXT_LINES)) &&
                    (xs >= videoMode.h_lag_start) &&
                    (dx < 12'(LINE_BITS));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      de_s1   <= 1'b0;
      bar_s1  <= 1'b0;
      text_s1 <= 1'b0;
      row_s1  <= '0;
      bit_s1  <= '0;
    end else begin
      de_s1   <= de;
      bar_s1  <= lit && edge_hit && field_hit;
      text_s1 <= text_hit;
      row_s1  <= row_full[ROW_W-1:0];
      bit_s1  <= BIT_W'(LINE_BITS - 1) - dx[BIT_W-1:0];
    end
  end

  assign text_idx = IDX_W'(row_s1) * IDX_W'(LINE_BITS) + IDX_W'(bit_s1);

  always_comb begin
    pix = 24'h000000;
    if (!de_s1) pix = 24'h000000;
    else if (bar_s1) pix = (cur_mode == COLOUR) ? flash_rgb : 24'hFFFFFF;
    else if (text_s1 && text_bits[text_idx]) pix = 24'hFFFFFF;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data   <= 24'h000000;
      de_out <= 1'b0;
    end else begin
      data   <= pix;
      de_out <= de_s1;
    end
  end

endmodule

// File: tb/tb_lag_pattern_gen.sv
// Directed self-checking bench for lag_pattern_gen.
// Frame-level flash sequences plus a table of pixel geometry vectors.
module tb_lag_pattern_gen;
  import lag_pattern_gen_pkg::*;

  localparam logic [23:0] WH = 24'hFFFFFF;

  logic          clock = 1'b0;
  logic          reset_n;
  VideoMode      vm;
  logic [11:0]   counterX, counterY, vis_x, vis_y;
  logic          de, state;
  logic [35:0]   field_start, field_end;
  logic [5:0]    period, on_frames;
  logic [1:0]    mode;
  logic [23:0]   flash_rgb;
  logic [1023:0] text_bits;
  logic          starttrigger, de_out;
  logic [23:0]   data;

  int checks;
  int failures;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic        d;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[$];

  lag_pattern_gen dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .videoMode    (vm),
    .counterX     (counterX),
    .counterY     (counterY),
    .vis_x        (vis_x),
    .vis_y        (vis_y),
    .de           (de),
    .state        (state),
    .field_start  (field_start),
    .field_end    (field_end),
    .period       (period),
    .on_frames    (on_frames),
    .mode         (mode),
    .flash_rgb    (flash_rgb),
    .text_bits    (text_bits),
    .starttrigger (starttrigger),
    .de_out       (de_out),
    .data         (data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [23:0] act,
                     input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic probe(input string name, input logic [11:0] x,
                       input logic [11:0] y, input logic d,
                       input logic [23:0] exp);
    vis_x = x;
    vis_y = y;
    de = d;
    @(negedge clock);
    @(negedge clock);
    chk(name, data, exp);
    chk({name, "_de"}, {23'b0, de_out}, {23'b0, d});
    de = 1'b0;
  endtask

  task automatic frame(input string name, input logic exp_trig,
                       input logic [23:0] exp_bar);
    counterX = 12'd10;
    counterY = state ? 12'd6 : 12'd5;
    @(negedge clock);
    chk({name, "_trig"}, {23'b0, starttrigger}, {23'b0, exp_trig});
    counterX = 12'd0;
    counterY = 12'd0;
    @(negedge clock);
    chk({name, "_pulse"}, {23'b0, starttrigger}, 24'd0);
    probe({name, "_bar"}, 12'd0, 12'd10, 1'b1, exp_bar);
  endtask

  task automatic run_seq(input string name, input int n,
                         input logic [63:0] tm, input logic [63:0] lm,
                         input int chg_at, input logic [5:0] new_per);
    for (int k = 0; k < n; k++) begin
      if (k == chg_at) period = new_per;
      frame($sformatf("%s%0d", name, k), tm[k[5:0]],
            lm[k[5:0]] ? WH : 24'h0);
    end
  endtask

  task automatic do_reset(input int nf);
    reset_n = 1'b0;
    for (int f = 0; f < nf; f++) begin
      counterX = 12'd10;
      counterY = 12'd5;
      vis_x = 12'd0;
      vis_y = 12'd10;
      de = 1'b1;
      @(negedge clock);
      chk("rst_trig", {23'b0, starttrigger}, 24'd0);
      chk("rst_data", data, 24'd0);
      chk("rst_de", {23'b0, de_out}, 24'd0);
      counterX = 12'd0;
      counterY = 12'd0;
      repeat (3) @(negedge clock);
    end
    de = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    logic [23:0] expv[36];
    logic [11:0] yy;
    int xp;
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    vm = '0;
    vm.h_sync = 12'd4;
    vm.h_back_porch = 12'd6;
    vm.v_sync = 12'd2;
    vm.v_back_porch_1 = 12'd3;
    vm.v_back_porch_2 = 12'd4;
    vm.h_active = 12'd640;
    vm.h_field_width = 12'd32;
    vm.h_lag_divider = 4'd1;
    vm.v_lag_divider = 4'd1;
    vm.h_lag_start = 12'd20;
    vm.v_lag_start = 12'd200;
    counterX = '0;
    counterY = '0;
    vis_x = '0;
    vis_y = '0;
    de = 1'b0;
    state = 1'b0;
    field_start = {12'd400, 12'd100, 12'd10};
    field_end   = {12'd410, 12'd100, 12'd20};
    flash_rgb = 24'h123456;
    text_bits = {{256{1'b1}}, {128{2'b10}}, {256{1'b0}}, {256{1'b1}}};

    vecs.push_back('{12'd31,  12'd10,  1'b1, WH});
    vecs.push_back('{12'd32,  12'd10,  1'b1, 24'h0});
    vecs.push_back('{12'd608, 12'd15,  1'b1, WH});
    vecs.push_back('{12'd607, 12'd15,  1'b1, 24'h0});
    vecs.push_back('{12'd639, 12'd19,  1'b1, WH});
    vecs.push_back('{12'd0,   12'd20,  1'b1, 24'h0});
    vecs.push_back('{12'd0,   12'd100, 1'b1, 24'h0});
    vecs.push_back('{12'd0,   12'd99,  1'b1, 24'h0});
    vecs.push_back('{12'd5,   12'd400, 1'b1, WH});
    vecs.push_back('{12'd5,   12'd410, 1'b1, 24'h0});
    vecs.push_back('{12'd5,   12'd15,  1'b0, 24'h0});
    vecs.push_back('{12'd38,  12'd200, 1'b1, 24'h0});
    vecs.push_back('{12'd40,  12'd200, 1'b1, WH});
    vecs.push_back('{12'd551, 12'd200, 1'b1, WH});
    vecs.push_back('{12'd552, 12'd200, 1'b1, 24'h0});
    vecs.push_back('{12'd40,  12'd199, 1'b1, 24'h0});
    vecs.push_back('{12'd40,  12'd327, 1'b1, WH});
    vecs.push_back('{12'd40,  12'd328, 1'b1, 24'h0});
    vecs.push_back('{12'd40,  12'd231, 1'b1, WH});
    vecs.push_back('{12'd40,  12'd232, 1'b1, 24'h0});
    vecs.push_back('{12'd40,  12'd264, 1'b1, WH});
    vecs.push_back('{12'd42,  12'd264, 1'b1, 24'h0});

    // period 4, on 2, white; jitter stretches the cycle to 9 then 8 ticks
    period = 6'd4;
    on_frames = 6'd2;
    mode = 2'b00;
    do_reset(3);
    run_seq("p4on2_", 27, 64'h0202_0201, 64'h0606_0603, -1, 6'd0);

    period = 6'd0;
    on_frames = 6'd1;
    do_reset(1);
    run_seq("p0_", 12, 64'h203, 64'hFFF, -1, 6'd0);

    period = 6'd4;
    on_frames = 6'd0;
    do_reset(1);
    run_seq("on0_", 10, 64'h201, 64'h0, -1, 6'd0);

    on_frames = 6'd9;
    do_reset(1);
    run_seq("on9_", 20, 64'h20201, 64'hFFFFF, -1, 6'd0);

    period = 6'd4;
    on_frames = 6'd2;
    do_reset(1);
    run_seq("chg_", 34, 64'h2_0000_0201, 64'h2_0000_0603, 1, 6'd20);

    period = 6'd4;
    do_reset(1);
    state = 1'b1;
    counterX = 12'd10;
    counterY = 12'd5;
    @(negedge clock);
    chk("st1_wrongline", {23'b0, starttrigger}, 24'd0);
    counterX = 12'd0;
    counterY = 12'd0;
    @(negedge clock);
    frame("st1_", 1'b1, WH);
    state = 1'b0;

    mode = 2'b01;
    do_reset(1);
    frame("col_", 1'b1, 24'h123456);
    probe("col_txt_on", 12'd40, 12'd200, 1'b1, WH);
    probe("col_txt_off", 12'd40, 12'd232, 1'b1, 24'h0);
    probe("col_bar_r", 12'd620, 12'd405, 1'b1, 24'h123456);

    mode = 2'b10;
    do_reset(1);
    frame("stdy_first", 1'b0, WH);
    foreach (vecs[i])
      probe($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].d,
            vecs[i].exp);
    run_seq("stdy_", 10, 64'h0, 64'h3FF, -1, 6'd0);

    // Back-to-back text pixels: any latency slip shifts the stripes
    for (int r = 0; r < 2; r++) begin
      yy = (r == 0) ? 12'd264 : 12'd295;
      for (int i = 0; i < 36; i++) begin
        xp = (36 + i) >> 1;
        expv[i] = (xp >= 20 && ((xp - 20) % 2) == 0) ? WH : 24'h0;
      end
      for (int i = 0; i < 38; i++) begin
        if (i >= 2)
          chk($sformatf("txt_y%0d_x%0d", yy, 34 + i), data, expv[i-2]);
        if (i < 36) begin
          vis_x = 12'(36 + i);
          vis_y = yy;
          de = 1'b1;
        end else begin
          de = 1'b0;
        end
        @(negedge clock);
      end
    end

    mode = 2'b11;
    do_reset(1);
    run_seq("off_", 10, 64'h0, 64'h0, -1, 6'd0);

    mode = 2'b10;
    do_reset(1);
    frame("ar_", 1'b0, WH);
    vis_x = 12'd0;
    vis_y = 12'd10;
    de = 1'b1;
    repeat (3) @(negedge clock);
    chk("ar_before", data, WH);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_data", data, 24'h0);
    chk("ar_de", {23'b0, de_out}, 24'd0);
    mode = 2'b00;
    de = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    frame("ar_post", 1'b1, WH);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
